// File: rtl/nt_dopamine_motivation.sv
// Dopamine-driven motivation controller: debounces the dopamine level, then runs
// an IDLE/SEEK/ENGAGED/SATED handshake with a consumer that performs the action.
module nt_dopamine_motivation #(
  parameter int HOLD_CYCLES  = 8,
  parameter int ENGAGE_MAX   = 32,
  parameter int SATED_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dopamine_level,
  input  logic       action_ack,
  input  logic       action_done,
  output logic       action_req,
  output logic       reward_pulse,
  output logic [1:0] motivation,
  output logic [1:0] state
);

  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int T_MAX  = ((ENGAGE_MAX > SATED_CYCLES) ? ENGAGE_MAX : SATED_CYCLES) - 1;
  localparam int TIM_W  = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [TIM_W-1:0] ENG_LAST = TIM_W'(ENGAGE_MAX - 1);
  localparam logic [TIM_W-1:0] SAT_LAST = TIM_W'(SATED_CYCLES - 1);
  localparam logic [TIM_W-1:0] TIM_TOP  = TIM_W'(T_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    ENGAGED = 2'd2,
    SATED   = 2'd3
  } state_t;

  state_t           cur_state, next_state;
  logic [1:0]       cand, filt;
  logic [CNT_W-1:0] cnt;
  logic [TIM_W-1:0] timer, timer_next, timer_inc;
  logic             reward_next;

  // A new level is only accepted after it has been seen unchanged for HOLD_CYCLES edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= 2'd0;
      cnt  <= '0;
      filt <= 2'd0;
    end else if (dopamine_level != cand) begin
      cand <= dopamine_level;
      cnt  <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 1'b1;
    end else begin
      filt <= cand;
    end
  end

  assign timer_inc = (timer == TIM_TOP) ? timer : timer + 1'b1;

  always_comb begin
    next_state  = cur_state;
    timer_next  = timer;
    reward_next = 1'b0;
    case (cur_state)
      IDLE: begin
        timer_next = '0;
        if (filt >= 2'd2) next_state = SEEK;
      end
      SEEK: begin
        timer_next = '0;
        if (action_ack)         next_state = ENGAGED;
        else if (filt <= 2'd1)  next_state = IDLE;
      end
      ENGAGED: begin
        timer_next = timer_inc;
        // Only a real completion earns a reward, even if it lands on the timeout cycle.
        if (action_done || (timer == ENG_LAST)) begin
          next_state  = SATED;
          timer_next  = '0;
          reward_next = action_done;
        end
      end
      SATED: begin
        timer_next = timer_inc;
        if (timer == SAT_LAST) begin
          next_state = IDLE;
          timer_next = '0;
        end
      end
      default: begin
        next_state = IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state    <= IDLE;
      timer        <= '0;
      reward_pulse <= 1'b0;
      action_req   <= 1'b0;
    end else begin
      cur_state    <= next_state;
      timer        <= timer_next;
      reward_pulse <= reward_next;
      action_req   <= (next_state == SEEK);
    end
  end

  assign motivation = filt;
  assign state      = cur_state;

endmodule

// File: tb/tb_nt_dopamine_motivation.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against a run-length / phase-count reference model.
module tb_nt_dopamine_motivation;

  localparam int HOLD   = 8;
  localparam int ENGAGE = 32;
  localparam int SATED  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dopamine_level = 2'd0;
  logic       action_ack = 1'b0;
  logic       action_done = 1'b0;
  logic       action_req;
  logic       reward_pulse;
  logic [1:0] motivation;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: filter as "length of the current run of identical samples",
  // FSM as a phase number plus number of cycles already spent in that phase.
  int         m_run;
  logic [1:0] m_last;
  logic [1:0] m_filt;
  int         m_state;
  int         m_cycles;
  logic       m_req;
  logic       m_pulse;

  nt_dopamine_motivation #(
    .HOLD_CYCLES (HOLD),
    .ENGAGE_MAX  (ENGAGE),
    .SATED_CYCLES(SATED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dopamine_level(dopamine_level),
    .action_ack    (action_ack),
    .action_done   (action_done),
    .action_req    (action_req),
    .reward_pulse  (reward_pulse),
    .motivation    (motivation),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic [1:0] lvl, input logic a, input logic d);
    logic [1:0] old_filt;
    if (r) begin
      m_run = 1; m_last = 2'd0; m_filt = 2'd0;
      m_state = 0; m_cycles = 0; m_req = 1'b0; m_pulse = 1'b0;
      return;
    end
    old_filt = m_filt;
    if (lvl == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = lvl;
      m_run  = 1;
    end
    if (m_run >= HOLD + 1) m_filt = lvl;
    m_pulse = 1'b0;
    case (m_state)
      0: if (old_filt >= 2) m_state = 1;
      1: begin
        if (a) begin m_state = 2; m_cycles = 0; end
        else if (old_filt <= 1) m_state = 0;
      end
      2: begin
        m_cycles++;
        if (d || m_cycles == ENGAGE) begin
          m_state = 3; m_pulse = d; m_cycles = 0;
        end
      end
      default: begin
        m_cycles++;
        if (m_cycles == SATED) begin m_state = 0; m_cycles = 0; end
      end
    endcase
    m_req = (m_state == 1);
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] lvl, input logic a, input logic d);
    rst = r; dopamine_level = lvl; action_ack = a; action_done = d;
    @(posedge clk);
    modelStep(r, lvl, a, d);
    #1;
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("motivation", 32'(motivation), 32'(m_filt));
    checkOutput("action_req", 32'(action_req), 32'(m_req));
    checkOutput("reward_pulse", 32'(reward_pulse), 32'(m_pulse));
  endtask

  initial begin
    #2;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_motivation", 32'(motivation), 32'd0);
    checkOutput("reset_req", 32'(action_req), 32'd0);

    // Filter acceptance: 9th edge accepts, 10th edge enters SEEK.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("accept_not_yet", 32'(motivation), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("accept_9th", 32'(motivation), 32'd2);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("seek_10th", 32'(state), 32'd1);
    checkOutput("req_10th", 32'(action_req), 32'd1);

    // Full handshake with reward.
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    checkOutput("hs_engaged", 32'(state), 32'd2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("hs_sated", 32'(state), 32'd3);
    checkOutput("hs_pulse", 32'(reward_pulse), 32'd1);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
    checkOutput("hs_pulse_once", 32'(reward_pulse), 32'd0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("hs_still_sated", 32'(state), 32'd3);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("hs_idle", 32'(state), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("hs_reseek", 32'(state), 32'd1);

    // Timeout without completion.
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("to_still_engaged", 32'(state), 32'd2);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("to_sated", 32'(state), 32'd3);
    checkOutput("to_no_pulse", 32'(reward_pulse), 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("to_idle", 32'(state), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);

    // Ack wins over a dropped filt; done on the timeout cycle still rewards.
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
    checkOutput("sim_filt_drop", 32'(motivation), 32'd1);
    checkOutput("sim_still_seek", 32'(state), 32'd1);
    applyStimulus(1'b0, 2'd1, 1'b1, 1'b0);
    checkOutput("sim_ack_wins", 32'(state), 32'd2);
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b1);
    checkOutput("sim_done_timeout_pulse", 32'(reward_pulse), 32'd1);

    // Reset in the middle of an engagement.
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    checkOutput("rst_mid_engaged", 32'(state), 32'd2);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_motivation", 32'(motivation), 32'd0);
    checkOutput("rst_pulse", 32'(reward_pulse), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
    checkOutput("rst_no_late_pulse", 32'(reward_pulse), 32'd0);

    // Randomized traffic with sticky levels so the filter actually accepts values.
    begin
      logic [1:0] lvl;
      lvl = 2'd2;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) lvl = 2'($urandom_range(0, 3));
        applyStimulus(($urandom_range(0, 199) == 0), lvl,
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
